// File: rtl/systolic_skew_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_if
//
// Groups the vector handshake and the skewed array-edge outputs of the
// systolic skew feeder, so that producer and feeder are connected by one bundle.
//
// Parameters
//   ARR_SIZE       array dimension N (lanes per vector, vectors per tile)
//   HORIZONTAL_BW  bits per lane element
//
// Signals
//   in_valid          producer -> feeder : in_data holds a valid vector
//   in_ready          feeder -> producer : feeder accepts a vector this cycle
//   in_data           producer -> feeder : one vector, lane k at [k*BW +: BW]
//   horizontal_input  feeder -> array    : skewed lanes for the array's left edge
//   out_valid         feeder -> array    : horizontal_input belongs to a tile
//   tile_done         feeder -> array    : pulse on the last stream cycle
//
// Modports
//   slave   the feeder
//   master  the producer/consumer side (the testbench or the surrounding system)
// -----------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
   parameter int ARR_SIZE      = 4,
   parameter int HORIZONTAL_BW = 16
);

   logic                              in_valid;
   logic                              in_ready;
   logic [HORIZONTAL_BW*ARR_SIZE-1:0] in_data;
   logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input;
   logic                              out_valid;
   logic                              tile_done;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output horizontal_input,
      output out_valid,
      output tile_done
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  horizontal_input,
      input  out_valid,
      input  tile_done
   );

endinterface

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Collects N vectors of N lanes into a tile buffer, then streams the tile into
// the left edge of an N x N systolic array with the classic diagonal skew:
// at stream count c, lane k carries row (c-k) of the tile, or zero when that
// row does not exist. A tile streams for exactly 2N-1 cycles, then the feeder
// returns to loading. Lane data is passed bit-exact.
//
// FSM states
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_LOAD   | in_ready=1; each accepted beat is written to row ld_cnt
//   ST_STREAM | in_ready=0; st_cnt walks 0..2N-2, driving skewed lanes
//
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   systolic_skew_feeder_if.slave (handshake in, skewed lanes out)
//
// horizontal_input, out_valid and tile_done are registered: the values for
// stream count c appear in the cycle after the FSM sits at count c. As a
// result tile_done coincides with the cycle where the FSM is already back in
// ST_LOAD, so the next tile can start loading without a bubble.
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
   parameter int ARR_SIZE      = 4,
   parameter int HORIZONTAL_BW = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   systolic_skew_feeder_if.slave   bus
);

   localparam int N     = ARR_SIZE;
   localparam int BW    = HORIZONTAL_BW;
   localparam int W     = N * BW;
   localparam int CNT_W = $clog2(2 * N);

   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * N - 2);

   typedef enum logic {
      ST_LOAD   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
   logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

   logic [W-1:0]     tile_q [N];

   logic [W-1:0]     hin_q, hin_d;
   logic             out_valid_q, out_valid_d;
   logic             tile_done_q, tile_done_d;

   logic             accept;

   assign accept = bus.in_valid && (state_q == ST_LOAD);

   // ---------------------------------------------------------------------------
   // FSM: next state and counters
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      st_cnt_d = st_cnt_q;
      unique case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (ld_cnt_q == LOAD_LAST) begin
                  ld_cnt_d = '0;
                  st_cnt_d = '0;
                  state_d  = ST_STREAM;
               end else begin
                  ld_cnt_d = ld_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_STREAM: begin
            if (st_cnt_q == STREAM_LAST) begin
               st_cnt_d = '0;
               state_d  = ST_LOAD;
            end else begin
               st_cnt_d = st_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = ST_LOAD;
            ld_cnt_d = '0;
            st_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Skewed lane selection. Lane k shows row r exactly when st_cnt == r + k;
   // comparing against constant r + k avoids any subtraction or variable
   // array index on the read path.
   // ---------------------------------------------------------------------------
   always_comb begin
      hin_d       = '0;
      out_valid_d = (state_q == ST_STREAM);
      tile_done_d = (state_q == ST_STREAM) && (st_cnt_q == STREAM_LAST);
      if (state_q == ST_STREAM) begin
         for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
               if (st_cnt_q == CNT_W'(r + k)) begin
                  hin_d[k*BW +: BW] = tile_q[r][k*BW +: BW];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State, counters and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_LOAD;
         ld_cnt_q    <= '0;
         st_cnt_q    <= '0;
         hin_q       <= '0;
         out_valid_q <= 1'b0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         st_cnt_q    <= st_cnt_d;
         hin_q       <= hin_d;
         out_valid_q <= out_valid_d;
         tile_done_q <= tile_done_d;
      end
   end

   // Tile buffer carries no reset: its contents are only observed after a
   // complete tile has been written since the last reset.
   always_ff @(posedge clk) begin
      for (int r = 0; r < N; r++) begin
         if (accept && (ld_cnt_q == CNT_W'(r))) begin
            tile_q[r] <= bus.in_data;
         end
      end
   end

   assign bus.in_ready         = (state_q == ST_LOAD);
   assign bus.horizontal_input = hin_q;
   assign bus.out_valid        = out_valid_q;
   assign bus.tile_done        = tile_done_q;

   // ---------------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------------
   a_done_in_stream : assert property (@(posedge clk) disable iff (rst)
      bus.tile_done |-> bus.out_valid);

   a_st_cnt_range : assert property (@(posedge clk) disable iff (rst)
      st_cnt_q <= STREAM_LAST);

   a_ld_cnt_range : assert property (@(posedge clk) disable iff (rst)
      ld_cnt_q <= LOAD_LAST);

   a_ld_idle_in_stream : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_STREAM) |-> (ld_cnt_q == '0));

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int BW = 16;
   localparam int W  = N * BW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   systolic_skew_feeder_if #(.ARR_SIZE(N), .HORIZONTAL_BW(BW)) bus ();

   systolic_skew_feeder #(.ARR_SIZE(N), .HORIZONTAL_BW(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] cap [7];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Row r, lane k holds r*16 + k (hex digits "r k").
   function automatic logic [W-1:0] row_word(input int r);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < N; k++) w[k*BW +: BW] = BW'(r * 16 + k);
      return w;
   endfunction

   // Expected skewed lanes at stream count c for a tile whose row 0 is rb.
   function automatic logic [W-1:0] exp_lanes(input int rb, input int c);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < N; k++) begin
         if ((c - k >= 0) && (c - k <= N - 1))
            w[k*BW +: BW] = BW'((rb + c - k) * 16 + k);
      end
      return w;
   endfunction

   task automatic send_beat(input logic [W-1:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("beat_timeout", 1'b0, 1'b1);
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   // Entered at the cycle right after the last beat was accepted.
   task automatic check_stream(input int rb, input bit junk, input string tag);
      chk({tag, " pre ov"},  bus.out_valid, 1'b0);
      chk({tag, " pre rdy"}, bus.in_ready, 1'b0);
      bus.in_valid = junk;
      bus.in_data  = junk ? {$urandom(), $urandom()} : '0;
      for (int c = 0; c < 7; c++) begin
         step();
         if (junk && c < 6) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom(), $urandom()};
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
         end
         cap[c] = bus.horizontal_input;
         chk($sformatf("%s c%0d ov", tag, c),  bus.out_valid, 1'b1);
         chk($sformatf("%s c%0d hin", tag, c), bus.horizontal_input, exp_lanes(rb, c));
         chk($sformatf("%s c%0d done", tag, c), bus.tile_done, (c == 6));
         chk($sformatf("%s c%0d rdy", tag, c),  bus.in_ready, (c == 6));
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " ov"},   bus.out_valid, 1'b0);
      chk({tag, " hin"},  bus.horizontal_input, '0);
      chk({tag, " done"}, bus.tile_done, 1'b0);
      chk({tag, " rdy"},  bus.in_ready, 1'b1);
   endtask

   initial begin
      bit            bad;
      int            beat;
      bit            acc;
      logic [W-1:0]  c3_const;
      logic [W-1:0]  c6_const;

      c3_const = 64'h0003_0012_0021_0030;
      c6_const = 64'h0033_0000_0000_0000;

      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      #2 rst = 1'b0;
      step();
      check_idle("post_reset");

      // Basic tile, rows 0..3
      for (int r = 0; r < 4; r++) send_beat(row_word(r));
      check_stream(0, 1'b0, "t1");
      chk("t1 cyc0 const", cap[0], '0);
      chk("t1 cyc3 const", cap[3], c3_const);
      chk("t1 cyc6 const", cap[6], c6_const);
      step();
      check_idle("t1 after");

      // Back-to-back tiles with in_valid held high for 8 beats
      beat = 0;
      for (int t = 0; t < 25; t++) begin
         chk($sformatf("b2b t%0d rdy", t), bus.in_ready,
             !((t >= 4 && t <= 10) || (t >= 15 && t <= 21)));
         chk($sformatf("b2b t%0d ov", t), bus.out_valid,
             ((t >= 5 && t <= 11) || (t >= 16 && t <= 22)));
         chk($sformatf("b2b t%0d done", t), bus.tile_done, (t == 11 || t == 22));
         if (t >= 5 && t <= 11)
            chk($sformatf("b2b t%0d hin", t), bus.horizontal_input, exp_lanes(0, t - 5));
         else if (t >= 16 && t <= 22)
            chk($sformatf("b2b t%0d hin", t), bus.horizontal_input, exp_lanes(4, t - 16));
         else
            chk($sformatf("b2b t%0d hin", t), bus.horizontal_input, '0);
         bus.in_valid = (beat < 8);
         bus.in_data  = row_word(beat);
         acc = bus.in_ready && bus.in_valid;
         step();
         if (acc) beat++;
      end
      chk("b2b beats", 64'(beat), 64'd8);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      step();

      // Async reset during stream cycle 3
      for (int r = 2; r < 6; r++) send_beat(row_word(r));
      repeat (4) step();
      chk("rst_mid c3 hin", bus.horizontal_input, exp_lanes(2, 3));
      #2 rst = 1'b1;
      #1;
      check_idle("rst_mid async");
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int r = 8; r < 12; r++) send_beat(row_word(r));
      check_stream(8, 1'b0, "after_rst");
      step();
      check_idle("after_rst idle");

      // Reset mid-load discards the partial tile
      send_beat(row_word(20));
      send_beat(row_word(21));
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      step();
      check_idle("rst_load");
      for (int r = 12; r < 16; r++) send_beat(row_word(r));
      check_stream(12, 1'b0, "rst_load");
      step();

      // Partial tile waits indefinitely
      for (int r = 5; r < 8; r++) send_beat(row_word(r));
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.out_valid || bus.tile_done || (bus.horizontal_input != '0) || !bus.in_ready)
            bad = 1'b1;
      end
      chk("idle50 quiet", bad, 1'b0);
      send_beat(row_word(8));
      check_stream(5, 1'b0, "partial");
      step();
      check_idle("partial idle");

      // Gapped loading plus junk traffic while streaming
      for (int r = 0; r < 4; r++) begin
         send_beat(row_word(r));
         if (r < 3) repeat (r + 1) step();
      end
      check_stream(0, 1'b1, "gap_junk");
      chk("gap_junk cyc3 const", cap[3], c3_const);
      chk("gap_junk cyc6 const", cap[6], c6_const);
      step();
      check_idle("gap_junk idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
